// File: rtl/cpu_control_fsm.sv
// Multi-cycle control sequencer for the 16-bit turtle CPU: fetch, decode, memory
// sequencing, program counter ownership and illegal-encoding trap.
module cpu_control_fsm #(
  parameter int PC_WIDTH    = 12,
  parameter int INSTR_WIDTH = 16,
  parameter int RESET_PC    = 0
) (
  input  logic                   clk,
  input  logic                   rst,
  output logic                   imem_req_valid,
  input  logic                   imem_req_ready,
  output logic [PC_WIDTH-1:0]    imem_addr,
  input  logic                   imem_rsp_valid,
  input  logic [INSTR_WIDTH-1:0] imem_rsp_data,
  output logic                   dmem_req_valid,
  input  logic                   dmem_req_ready,
  output logic                   dmem_we,
  input  logic                   dmem_rsp_valid,
  input  logic                   branch_taken,
  input  logic [PC_WIDTH-1:0]    jump_reg_target,
  output logic [PC_WIDTH-1:0]    pc,
  output logic [INSTR_WIDTH-1:0] instr,
  output logic                   alu_en,
  output logic                   alu_src_imm,
  output logic                   regfile_we,
  output logic                   retire,
  output logic                   illegal_instr,
  output logic [2:0]             dbg_state_o
);

  // Handshakes: a transfer happens on a rising edge where valid && ready are both
  // high; valid never drops before that edge and its payload stays stable meanwhile.

  typedef enum logic [2:0] {
    S_IDLE       = 3'd0,
    S_FETCH_REQ  = 3'd1,
    S_FETCH_WAIT = 3'd2,
    S_EXECUTE    = 3'd3,
    S_MEM_REQ    = 3'd4,
    S_MEM_WAIT   = 3'd5,
    S_TRAP       = 3'd6
  } state_e;

  localparam logic [2:0] OP_ALU_IMM = 3'b000;
  localparam logic [2:0] OP_ALU_REG = 3'b001;
  localparam logic [2:0] OP_MISC    = 3'b010;
  localparam logic [2:0] OP_JMP_IMM = 3'b100;
  localparam logic [2:0] OP_JMP_REG = 3'b111;
  localparam logic [3:0] FN_LOAD    = 4'b0000;
  localparam logic [3:0] FN_STORE   = 4'b0001;
  localparam logic [3:0] FN_GET     = 4'b0010;
  localparam logic [3:0] FN_PUT     = 4'b0011;
  localparam logic [3:0] FN_SET     = 4'b0100;

  state_e                 state_q, state_d;
  logic [PC_WIDTH-1:0]    pc_q, pc_d;
  logic [INSTR_WIDTH-1:0] instr_q, instr_d;
  logic                   illegal_q, illegal_d;

  logic [2:0]          opcode;
  logic [3:0]          funct;
  logic [PC_WIDTH-1:0] imm_target;
  logic [PC_WIDTH-1:0] pc_inc;
  logic                is_store;

  assign opcode     = instr_q[3:1];
  assign funct      = instr_q[7:4];
  assign imm_target = instr_q[PC_WIDTH+3:4];
  assign pc_inc     = pc_q + PC_WIDTH'(1);
  assign is_store   = (funct == FN_STORE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= S_IDLE;
      pc_q      <= PC_WIDTH'(RESET_PC);
      instr_q   <= '0;
      illegal_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      instr_q   <= instr_d;
      illegal_q <= illegal_d;
    end
  end

  always_comb begin
    state_d        = state_q;
    pc_d           = pc_q;
    instr_d        = instr_q;
    illegal_d      = illegal_q;
    imem_req_valid = 1'b0;
    dmem_req_valid = 1'b0;
    dmem_we        = 1'b0;
    alu_en         = 1'b0;
    alu_src_imm    = 1'b0;
    regfile_we     = 1'b0;
    retire         = 1'b0;
    case (state_q)
      S_IDLE: state_d = S_FETCH_REQ;
      S_FETCH_REQ: begin
        imem_req_valid = 1'b1;
        if (imem_req_ready) state_d = S_FETCH_WAIT;
      end
      S_FETCH_WAIT: begin
        if (imem_rsp_valid) begin
          instr_d = imem_rsp_data;
          state_d = S_EXECUTE;
        end
      end
      S_EXECUTE: begin
        // Every retiring path returns to fetch; memory ops and traps override below.
        retire  = 1'b1;
        state_d = S_FETCH_REQ;
        pc_d    = pc_inc;
        if (instr_q[0]) begin
          pc_d = branch_taken ? imm_target : pc_inc;
        end else begin
          case (opcode)
            OP_ALU_IMM: begin
              alu_en      = 1'b1;
              alu_src_imm = 1'b1;
              regfile_we  = 1'b1;
            end
            OP_ALU_REG: begin
              alu_en     = 1'b1;
              regfile_we = 1'b1;
            end
            OP_MISC: begin
              if (funct == FN_LOAD || funct == FN_STORE) begin
                retire  = 1'b0;
                pc_d    = pc_q;
                state_d = S_MEM_REQ;
              end else if (funct == FN_GET || funct == FN_PUT || funct == FN_SET) begin
                regfile_we = 1'b1;
              end else begin
                retire    = 1'b0;
                pc_d      = pc_q;
                illegal_d = 1'b1;
                state_d   = S_TRAP;
              end
            end
            OP_JMP_IMM: pc_d = imm_target;
            OP_JMP_REG: pc_d = jump_reg_target;
            default: begin
              retire    = 1'b0;
              pc_d      = pc_q;
              illegal_d = 1'b1;
              state_d   = S_TRAP;
            end
          endcase
        end
      end
      S_MEM_REQ: begin
        dmem_req_valid = 1'b1;
        dmem_we        = is_store;
        if (dmem_req_ready) state_d = S_MEM_WAIT;
      end
      S_MEM_WAIT: begin
        if (dmem_rsp_valid) begin
          regfile_we = !is_store;
          retire     = 1'b1;
          pc_d       = pc_inc;
          state_d    = S_FETCH_REQ;
        end
      end
      S_TRAP: state_d = S_TRAP;
      default: state_d = S_IDLE;
    endcase
  end

  assign imem_addr     = pc_q;
  assign pc            = pc_q;
  assign instr         = instr_q;
  assign illegal_instr = illegal_q;
  assign dbg_state_o   = state_q;

endmodule
